tlul_initiator: RTL and testbench

TileLink-UL initiator (master) that turns a simple tagged request/response port into A-channel Get/Put/Atomic messages and returns D-channel responses. It is the requesting counterpart of the TL-UL peripheral slaves (CLINT, PLIC, UART) on the 32-bit peripheral bus. It issues up to OUTSTANDING concurrent transactions using distinct source IDs and returns responses out of order, tagged by source.

---
 rtl/tlul_initiator.sv | 181 ++++++++++++++++++
 tb/tb_tlul_initiator.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_initiator.sv
// tlul_initiator: turns tagged read/write/atomic requests into TL-UL A messages and returns D responses by source.
// Latency: request accepted in cycle N shows on A in N+1; D handshake in N shows on rsp in N+1.
// Backpressure: one A register (req_ready drops while it is stalled or no source is free); one response register (tl_d_ready drops while it is stalled).
module tlul_initiator #(
    parameter int TL_RS       = 4,
    parameter int OUTSTANDING = 4,
    parameter int AW          = 32
) (
    input  logic             tlul_clock_i,
    input  logic             tlul_reset_ni,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [2:0]       req_param,
    input  logic [1:0]       req_size,
    input  logic [AW-1:0]    req_address,
    input  logic [3:0]       req_mask,
    input  logic [31:0]      req_data,
    output logic [TL_RS-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TL_RS-1:0] rsp_tag,
    output logic [31:0]      rsp_data,
    output logic             rsp_denied,
    output logic             rsp_corrupt,
    output logic [2:0]       tl_a_opcode,
    output logic [2:0]       tl_a_param,
    output logic [3:0]       tl_a_size,
    output logic [TL_RS-1:0] tl_a_source,
    output logic [AW-1:0]    tl_a_address,
    output logic [3:0]       tl_a_mask,
    output logic [31:0]      tl_a_data,
    output logic             tl_a_corrupt,
    output logic             tl_a_valid,
    input  logic             tl_a_ready,
    input  logic [2:0]       tl_d_opcode,
    input  logic [1:0]       tl_d_param,
    input  logic [3:0]       tl_d_size,
    input  logic [TL_RS-1:0] tl_d_source,
    input  logic             tl_d_denied,
    input  logic [31:0]      tl_d_data,
    input  logic             tl_d_corrupt,
    input  logic             tl_d_valid,
    output logic             tl_d_ready,
    output logic             proto_err,
    output logic             busy
);

    logic [OUTSTANDING-1:0] inflight;
    logic [OUTSTANDING-1:0] free_onehot;
    logic [OUTSTANDING-1:0] src_onehot;
    logic [OUTSTANDING-1:0] set_mask;
    logic [OUTSTANDING-1:0] clr_mask;
    logic [TL_RS-1:0]       free_idx;
    logic                   any_free;
    logic                   accept;
    logic                   a_fire;
    logic                   d_fire;
    logic                   d_good;
    logic                   d_opcode_ok;
    logic [3:0]             full_mask;
    logic [2:0]             a_opcode_nxt;
    logic                   unused_d;

    // D param and size carry nothing the requester needs
    assign unused_d = ^{tl_d_param, tl_d_size};

    // Lowest free source, plus one-hot decode of the D source against the slot range
    always_comb begin
        free_idx    = '0;
        any_free    = 1'b0;
        free_onehot = '0;
        src_onehot  = '0;
        for (int i = OUTSTANDING - 1; i >= 0; i--) begin
            src_onehot[i] = (tl_d_source == TL_RS'(i));
            if (!inflight[i]) begin
                free_idx = TL_RS'(i);
                any_free = 1'b1;
            end
        end
        for (int i = 0; i < OUTSTANDING; i++) begin
            free_onehot[i] = (free_idx == TL_RS'(i)) && !inflight[i];
        end
    end

    assign req_tag     = free_idx;
    assign req_ready   = (~tl_a_valid | tl_a_ready) & any_free;
    assign accept      = req_valid & req_ready;
    assign a_fire      = tl_a_valid & tl_a_ready;
    assign tl_d_ready  = ~rsp_valid | rsp_ready;
    assign d_fire      = tl_d_valid & tl_d_ready;
    assign d_opcode_ok = (tl_d_opcode == 3'd0) || (tl_d_opcode == 3'd1);
    // Source out of range decodes to no slot, so it can never match in-flight
    assign d_good      = d_fire & d_opcode_ok & (|(src_onehot & inflight));
    assign set_mask    = accept ? free_onehot : '0;
    assign clr_mask    = d_good ? src_onehot : '0;
    assign busy        = (|inflight) | tl_a_valid | rsp_valid;
    assign tl_a_corrupt = 1'b0;

    // Mask covering every byte lane of the addressed naturally-aligned container
    always_comb begin
        case (req_size)
            2'd0:    full_mask = 4'b0001 << req_address[1:0];
            2'd1:    full_mask = 4'b0011 << {req_address[1], 1'b0};
            default: full_mask = 4'hF;
        endcase
    end

    // Request kind to A opcode; writes split into full vs partial on the lane mask
    always_comb begin
        case (req_kind)
            2'd0:    a_opcode_nxt = 3'd4;
            2'd1:    a_opcode_nxt = (req_mask == full_mask) ? 3'd0 : 3'd1;
            2'd2:    a_opcode_nxt = 3'd2;
            default: a_opcode_nxt = 3'd3;
        endcase
    end

    // A message register: held stable until the responder takes it
    always_ff @(posedge tlul_clock_i or negedge tlul_reset_ni) begin
        if (!tlul_reset_ni) begin
            tl_a_valid   <= 1'b0;
            tl_a_opcode  <= '0;
            tl_a_param   <= '0;
            tl_a_size    <= '0;
            tl_a_source  <= '0;
            tl_a_address <= '0;
            tl_a_mask    <= '0;
            tl_a_data    <= '0;
        end else if (accept) begin
            tl_a_valid   <= 1'b1;
            tl_a_opcode  <= a_opcode_nxt;
            tl_a_param   <= req_kind[1] ? req_param : 3'd0;
            tl_a_size    <= {2'b00, req_size};
            tl_a_source  <= free_idx;
            tl_a_address <= req_address;
            tl_a_mask    <= req_mask;
            tl_a_data    <= req_data;
        end else if (a_fire) begin
            tl_a_valid   <= 1'b0;
        end
    end

    // Source bitmap: a slot freed this cycle is not reallocated until the next
    always_ff @(posedge tlul_clock_i or negedge tlul_reset_ni) begin
        if (!tlul_reset_ni) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight & ~clr_mask) | set_mask;
        end
    end

    // Response register: captures legal D beats, holds while rsp_ready is low
    always_ff @(posedge tlul_clock_i or negedge tlul_reset_ni) begin
        if (!tlul_reset_ni) begin
            rsp_valid   <= 1'b0;
            rsp_tag     <= '0;
            rsp_data    <= '0;
            rsp_denied  <= 1'b0;
            rsp_corrupt <= 1'b0;
        end else if (d_good) begin
            rsp_valid   <= 1'b1;
            rsp_tag     <= tl_d_source;
            rsp_data    <= (tl_d_opcode == 3'd1) ? tl_d_data : 32'd0;
            rsp_denied  <= tl_d_denied;
            rsp_corrupt <= tl_d_corrupt;
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

    // Sticky error on any consumed D beat that was not a legal response
    always_ff @(posedge tlul_clock_i or negedge tlul_reset_ni) begin
        if (!tlul_reset_ni) begin
            proto_err <= 1'b0;
        end else if (d_fire && !d_good) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tlul_initiator.sv
// tb_tlul_initiator: table-driven opcode vectors, hand sequences for the multi-cycle corners,
// then random traffic checked against a queue-based model of the initiator's rules.
module tb_tlul_initiator;
    localparam int TL_RS = 4;
    localparam int OUTSTANDING = 4;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             req_valid, req_ready;
    logic [1:0]       req_kind;
    logic [2:0]       req_param;
    logic [1:0]       req_size;
    logic [AW-1:0]    req_address;
    logic [3:0]       req_mask;
    logic [31:0]      req_data;
    logic [TL_RS-1:0] req_tag;
    logic             rsp_valid, rsp_ready;
    logic [TL_RS-1:0] rsp_tag;
    logic [31:0]      rsp_data;
    logic             rsp_denied, rsp_corrupt;
    logic [2:0]       tl_a_opcode, tl_a_param;
    logic [3:0]       tl_a_size;
    logic [TL_RS-1:0] tl_a_source;
    logic [AW-1:0]    tl_a_address;
    logic [3:0]       tl_a_mask;
    logic [31:0]      tl_a_data;
    logic             tl_a_corrupt, tl_a_valid, tl_a_ready;
    logic [2:0]       tl_d_opcode;
    logic [1:0]       tl_d_param;
    logic [3:0]       tl_d_size;
    logic [TL_RS-1:0] tl_d_source;
    logic             tl_d_denied;
    logic [31:0]      tl_d_data;
    logic             tl_d_corrupt, tl_d_valid, tl_d_ready;
    logic             proto_err, busy;

    tlul_initiator #(.TL_RS(TL_RS), .OUTSTANDING(OUTSTANDING), .AW(AW)) dut (
        .tlul_clock_i(clk), .tlul_reset_ni(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_param(req_param),
        .req_size(req_size), .req_address(req_address), .req_mask(req_mask), .req_data(req_data),
        .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .rsp_denied(rsp_denied), .rsp_corrupt(rsp_corrupt),
        .tl_a_opcode(tl_a_opcode), .tl_a_param(tl_a_param), .tl_a_size(tl_a_size),
        .tl_a_source(tl_a_source), .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask),
        .tl_a_data(tl_a_data), .tl_a_corrupt(tl_a_corrupt), .tl_a_valid(tl_a_valid),
        .tl_a_ready(tl_a_ready),
        .tl_d_opcode(tl_d_opcode), .tl_d_param(tl_d_param), .tl_d_size(tl_d_size),
        .tl_d_source(tl_d_source), .tl_d_denied(tl_d_denied), .tl_d_data(tl_d_data),
        .tl_d_corrupt(tl_d_corrupt), .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready),
        .proto_err(proto_err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_kind = 0; req_param = 0; req_size = 2; req_address = 0;
        req_mask = 4'hF; req_data = 0; rsp_ready = 1; tl_a_ready = 1;
        tl_d_valid = 0; tl_d_opcode = 0; tl_d_param = 0; tl_d_size = 0; tl_d_source = 0;
        tl_d_denied = 0; tl_d_data = 0; tl_d_corrupt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    task automatic send_d(input logic [3:0] src, input logic [2:0] op, input logic [31:0] dat);
        tl_d_valid = 1; tl_d_source = src; tl_d_opcode = op; tl_d_data = dat;
    endtask

    task automatic issue_read(input logic [31:0] addr);
        req_valid = 1; req_kind = 0; req_size = 2; req_mask = 4'hF; req_address = addr;
    endtask

    // Lanes of the naturally aligned container of 2^size bytes holding addr
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        int base;
        nb = 1 << size;
        base = (int'(addr[1:0]) / nb) * nb;
        return 4'(((1 << nb) - 1) << base);
    endfunction

    function automatic logic [2:0] exp_opc(input logic [1:0] kind, input logic [1:0] size,
                                           input logic [31:0] addr, input logic [3:0] mask);
        case (kind)
            2'd0:    return 3'd4;
            2'd1:    return (mask == lane_mask(size, addr)) ? 3'd0 : 3'd1;
            2'd2:    return 3'd2;
            default: return 3'd3;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [2:0]  d_op;
        logic [31:0] d_data;
        logic [2:0]  exp_op;
        logic [2:0]  exp_param;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[9];

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [3:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } a_t;
    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
        logic        den;
        logic        cor;
    } r_t;

    a_t aq[$];
    r_t rq[$];
    bit m_inflight[OUTSTANDING];
    bit m_issued[OUTSTANDING];
    int cand[$];
    bit d_pend;
    logic [3:0]  d_src;
    logic [2:0]  d_op;
    logic [31:0] d_dat;
    logic        d_den, d_cor;

    initial begin
        int low;
        logic exp_rr, exp_dr, a_hs, d_hs, req_hs;
        a_t na;
        r_t nr;

        vecs[0] = '{2'd0, 3'd0, 2'd2, 32'h0200BFF8, 4'hF,    32'h0,        3'd1, 32'h1234,     3'd4, 3'd0, 32'h1234};
        vecs[1] = '{2'd1, 3'd0, 2'd2, 32'h00001000, 4'hF,    32'hCAFEF00D, 3'd0, 32'hDEAD,     3'd0, 3'd0, 32'h0};
        vecs[2] = '{2'd1, 3'd0, 2'd0, 32'h00001001, 4'b0010, 32'h0000AB00, 3'd0, 32'h1,        3'd0, 3'd0, 32'h0};
        vecs[3] = '{2'd1, 3'd0, 2'd2, 32'h00001000, 4'b0011, 32'h11112222, 3'd0, 32'h0,        3'd1, 3'd0, 32'h0};
        vecs[4] = '{2'd3, 3'd1, 2'd2, 32'h00002000, 4'hF,    32'h0F0F0F0F, 3'd1, 32'h55,       3'd3, 3'd1, 32'h55};
        vecs[5] = '{2'd2, 3'd2, 2'd2, 32'h00002004, 4'hF,    32'h7,        3'd1, 32'h99,       3'd2, 3'd2, 32'h99};
        vecs[6] = '{2'd1, 3'd0, 2'd1, 32'h00003002, 4'b1100, 32'hBEEF0000, 3'd0, 32'h0,        3'd0, 3'd0, 32'h0};
        vecs[7] = '{2'd1, 3'd0, 2'd1, 32'h00003002, 4'b0011, 32'h0000BEEF, 3'd0, 32'h0,        3'd1, 3'd0, 32'h0};
        vecs[8] = '{2'd0, 3'd5, 2'd0, 32'h00004003, 4'b1000, 32'h0,        3'd1, 32'hA5A5A5A5, 3'd4, 3'd0, 32'hA5A5A5A5};

        // Reset values, observed while reset is held and after release
        idle_inputs();
        #1 rst_n = 0;
        #1;
        chk("rst_a_valid", tl_a_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_d_ready", tl_d_ready, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_req_tag", req_tag, 0);
        chk("rst_a_fields", {tl_a_opcode, tl_a_address, tl_a_data}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        step();
        rst_n = 1;
        step();
        chk("rel_busy", busy, 0);

        // Opcode/param/size vectors, each a full request-response round trip
        foreach (vecs[k]) begin
            req_valid = 1; req_kind = vecs[k].kind; req_param = vecs[k].param;
            req_size = vecs[k].size; req_address = vecs[k].addr; req_mask = vecs[k].mask;
            req_data = vecs[k].wdata;
            #1;
            chk($sformatf("v%0d_req_ready", k), req_ready, 1);
            chk($sformatf("v%0d_req_tag", k), req_tag, 0);
            step();
            req_valid = 0;
            chk($sformatf("v%0d_a_valid", k), tl_a_valid, 1);
            chk($sformatf("v%0d_a_opcode", k), tl_a_opcode, vecs[k].exp_op);
            chk($sformatf("v%0d_a_param", k), tl_a_param, vecs[k].exp_param);
            chk($sformatf("v%0d_a_misc", k),
                {tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data, tl_a_corrupt},
                {2'b00, vecs[k].size, 4'd0, vecs[k].addr, vecs[k].mask, vecs[k].wdata, 1'b0});
            send_d(4'd0, vecs[k].d_op, vecs[k].d_data);
            step();
            tl_d_valid = 0;
            chk($sformatf("v%0d_rsp_valid", k), rsp_valid, 1);
            chk($sformatf("v%0d_rsp_tag", k), rsp_tag, 0);
            chk($sformatf("v%0d_rsp_data", k), rsp_data, vecs[k].exp_rdata);
            chk($sformatf("v%0d_a_drained", k), tl_a_valid, 0);
            step();
            chk($sformatf("v%0d_rsp_gone", k), rsp_valid, 0);
            chk($sformatf("v%0d_idle", k), busy, 0);
        end

        // Fill all sources, then answer out of order
        for (int i = 0; i < 4; i++) begin
            issue_read(32'h100 + 32'(i * 4));
            #1;
            chk("full_req_ready", req_ready, 1);
            chk("full_req_tag", req_tag, i);
            step();
            chk("full_a_source", tl_a_source, i);
        end
        chk("full_blocked", req_ready, 0);
        step();
        chk("full_still_blocked", req_ready, 0);
        chk("full_a_drained", tl_a_valid, 0);
        req_valid = 0;
        send_d(4'd2, 3'd1, 32'h22);
        step();
        tl_d_valid = 0;
        chk("ooo_rsp_tag2", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd2, 32'h22});
        chk("ooo_free2", {req_ready, req_tag}, {1'b1, 4'd2});
        send_d(4'd0, 3'd0, 32'h77);
        step();
        tl_d_valid = 0;
        chk("ooo_rsp_tag0", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd0, 32'h0});
        chk("ooo_reuse0", req_tag, 0);
        issue_read(32'h200);
        step();
        chk("ooo_a_source0", tl_a_source, 0);
        // Free 0 and allocate in the same cycle: only slot 2 may be handed out
        send_d(4'd0, 3'd1, 32'h5);
        #1;
        chk("same_cycle_tag", req_tag, 2);
        step();
        req_valid = 0;
        tl_d_valid = 0;
        chk("same_cycle_a_src", tl_a_source, 2);
        chk("same_cycle_rsp", rsp_tag, 0);
        for (int s = 1; s < 4; s++) begin
            send_d(4'(s), 3'd0, 32'h0);
            step();
            tl_d_valid = 0;
            chk("drain_rsp_tag", rsp_tag, s);
        end
        step();
        chk("drain_idle", busy, 0);

        // A channel stall: fields held, further requests refused
        tl_a_ready = 0;
        issue_read(32'hABC);
        step();
        req_address = 32'h555;
        for (int i = 0; i < 5; i++) begin
            chk("astall_fields", {tl_a_valid, tl_a_address, tl_a_source}, {1'b1, 32'hABC, 4'd0});
            chk("astall_req_ready", req_ready, 0);
            step();
        end
        req_valid = 0;
        tl_a_ready = 1;
        #1;
        chk("astall_release", req_ready, 1);
        step();
        chk("astall_drained", tl_a_valid, 0);
        issue_read(32'hDEF);
        step();
        req_valid = 0;
        step();

        // Response stall: D held off, response fields held
        rsp_ready = 0;
        send_d(4'd0, 3'd1, 32'hA);
        step();
        send_d(4'd1, 3'd1, 32'hB);
        for (int i = 0; i < 3; i++) begin
            chk("dstall_rsp", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd0, 32'hA});
            chk("dstall_d_ready", tl_d_ready, 0);
            step();
        end
        rsp_ready = 1;
        #1;
        chk("dstall_d_ready_rel", tl_d_ready, 1);
        step();
        tl_d_valid = 0;
        chk("dstall_second", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd1, 32'hB});
        step();
        chk("dstall_idle", {rsp_valid, busy}, 0);

        // Stray source: dropped, sticky error
        send_d(4'd3, 3'd1, 32'h1);
        #1;
        chk("err_d_ready", tl_d_ready, 1);
        step();
        tl_d_valid = 0;
        chk("err_stray", {rsp_valid, proto_err}, {1'b0, 1'b1});
        step(); step(); step();
        chk("err_sticky", proto_err, 1);
        do_reset();
        chk("err_cleared", proto_err, 0);
        // Bad opcode on a live source
        issue_read(32'h10);
        step();
        req_valid = 0;
        send_d(4'd0, 3'd2, 32'h1);
        step();
        tl_d_valid = 0;
        chk("err_bad_op", {rsp_valid, proto_err, busy}, {1'b0, 1'b1, 1'b1});
        do_reset();

        // Asynchronous reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            issue_read(32'h300 + 32'(i * 4));
            step();
        end
        req_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_outputs", {tl_a_valid, rsp_valid, busy, proto_err, tl_d_ready, req_ready, req_tag},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0});
        step();
        rst_n = 1;
        send_d(4'd1, 3'd1, 32'h1);
        step();
        tl_d_valid = 0;
        chk("arst_late_d", {rsp_valid, proto_err}, {1'b0, 1'b1});
        do_reset();

        // Random traffic against the reference model
        d_pend = 0;
        for (int i = 0; i < OUTSTANDING; i++) begin
            m_inflight[i] = 0;
            m_issued[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                cand.delete();
                for (int i = 0; i < OUTSTANDING; i++) if (m_issued[i]) cand.push_back(i);
                if (cand.size() > 0) begin
                    d_src = 4'(cand[$urandom_range(0, cand.size() - 1)]);
                    m_issued[d_src] = 0;
                    d_pend = 1;
                    d_op = 3'($urandom_range(0, 1));
                    d_dat = $urandom;
                    d_den = 1'($urandom_range(0, 1));
                    d_cor = 1'($urandom_range(0, 1));
                end
            end
            tl_d_valid = d_pend; tl_d_source = d_src; tl_d_opcode = d_op; tl_d_data = d_dat;
            tl_d_denied = d_den; tl_d_corrupt = d_cor;
            req_valid = 1'($urandom_range(0, 1));
            req_kind = 2'($urandom_range(0, 3));
            req_param = 3'($urandom_range(0, 7));
            req_size = 2'($urandom_range(0, 2));
            req_address = $urandom;
            req_data = $urandom;
            req_mask = ($urandom_range(0, 1) == 1) ? lane_mask(req_size, req_address) : 4'($urandom);
            tl_a_ready = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            low = -1;
            for (int i = OUTSTANDING - 1; i >= 0; i--) if (!m_inflight[i]) low = i;
            exp_rr = (aq.size() == 0 || tl_a_ready) && (low >= 0);
            exp_dr = (rq.size() == 0) || rsp_ready;
            chk("r_req_ready", req_ready, exp_rr);
            if (low >= 0) chk("r_req_tag", req_tag, low);
            chk("r_a_valid", tl_a_valid, aq.size() != 0);
            if (aq.size() != 0)
                chk("r_a_fields", {tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address,
                                   tl_a_mask, tl_a_data}, aq[0]);
            chk("r_rsp_valid", rsp_valid, rq.size() != 0);
            if (rq.size() != 0)
                chk("r_rsp_fields", {rsp_tag, rsp_data, rsp_denied, rsp_corrupt}, rq[0]);
            chk("r_d_ready", tl_d_ready, exp_dr);
            chk("r_busy", busy, (m_inflight.sum() with (int'(item)) != 0) || aq.size() != 0 || rq.size() != 0);
            chk("r_proto_err", proto_err, 0);
            a_hs = (aq.size() != 0) && tl_a_ready;
            req_hs = req_valid && exp_rr;
            d_hs = d_pend && exp_dr;
            if (a_hs) begin
                m_issued[aq[0].src] = 1;
                void'(aq.pop_front());
            end
            if (rq.size() != 0 && rsp_ready) void'(rq.pop_front());
            if (d_hs) begin
                nr.tag = d_src;
                nr.data = (d_op == 3'd1) ? d_dat : 32'd0;
                nr.den = d_den;
                nr.cor = d_cor;
                rq.push_back(nr);
                m_inflight[d_src] = 0;
                d_pend = 0;
            end
            if (req_hs) begin
                m_inflight[low] = 1;
                na.op = exp_opc(req_kind, req_size, req_address, req_mask);
                na.param = (req_kind >= 2) ? req_param : 3'd0;
                na.size = {2'b00, req_size};
                na.src = 4'(low);
                na.addr = req_address;
                na.mask = req_mask;
                na.data = req_data;
                aq.push_back(na);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
